// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads instruction memory and holds each word for CPU_FSM.
// Optional halt-word detection is enabled by defining IFU_HALT_DETECT_EN.
module instr_fetch_unit #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [15:0]       HALT_WORD = 16'hFFFF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              PCEn,
  input  logic              BranchTaken,
  input  logic [ADDR_W-1:0] TargetAddr,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRdEn,
  input  logic [15:0]       MemData,
  output logic [15:0]       Instr,
  output logic              InstrValid,
  output logic [ADDR_W-1:0] PC,
  output logic              Halted
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3
`ifdef IFU_HALT_DETECT_EN
    , S_HALT = 3'd4
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // PCEn/BranchTaken only matter in HOLD; MemData is only sampled leaving WAIT.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        instr_d = MemData;
        state_d = S_HOLD;
`ifdef IFU_HALT_DETECT_EN
        if (MemData == HALT_WORD) begin
          state_d = S_HALT;
        end
`endif
      end
      S_HOLD: begin
        if (PCEn) begin
          pc_d    = BranchTaken ? TargetAddr : pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          state_d = S_FETCH;
        end
      end
`ifdef IFU_HALT_DETECT_EN
      S_HALT:  state_d = S_HALT;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign MemAddr    = pc_q;
  assign PC         = pc_q;
  assign Instr      = instr_q;
  assign MemRdEn    = (state_q == S_FETCH);
  assign InstrValid = (state_q == S_HOLD);

`ifdef IFU_HALT_DETECT_EN
  assign Halted = (state_q == S_HALT);
`else
  // Without halt detection the halt encoding is an ordinary instruction.
  logic unused_halt_match;
  assign unused_halt_match = (MemData == HALT_WORD);
  assign Halted            = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, corner sequences and
// randomized accepts checked against a PC/memory model. Honours IFU_HALT_DETECT_EN.
module tb_instr_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        PCEn;
  logic        BranchTaken;
  logic [15:0] TargetAddr;
  logic [15:0] MemAddr;
  logic        MemRdEn;
  logic [15:0] MemData = 16'h0000;
  logic [15:0] Instr;
  logic        InstrValid;
  logic [15:0] PC;
  logic        Halted;

  logic [15:0] mem [0:65535];
  logic [15:0] model_pc;
  int          total = 0;
  int          bad   = 0;

  typedef struct {
    logic        branch;
    logic [15:0] target;
    logic [15:0] exp_pc;
    logic [15:0] exp_instr;
  } vec_t;

  vec_t vecs [6];

  instr_fetch_unit dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .PCEn       (PCEn),
    .BranchTaken(BranchTaken),
    .TargetAddr (TargetAddr),
    .MemAddr    (MemAddr),
    .MemRdEn    (MemRdEn),
    .MemData    (MemData),
    .Instr      (Instr),
    .InstrValid (InstrValid),
    .PC         (PC),
    .Halted     (Halted)
  );

  always #5 Clk = ~Clk;

  // One-cycle synchronous instruction memory.
  always @(posedge Clk) begin
    if (MemRdEn) MemData <= mem[MemAddr];
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // Asserts reset at the current time, then releases it and follows the three-edge start-up.
  task automatic run_reset_sequence(input string name);
    Reset = 1'b1;
    #1;
    check_output({name, " rst InstrValid"}, 32'(InstrValid), 32'd0);
    check_output({name, " rst MemRdEn"},    32'(MemRdEn),    32'd0);
    check_output({name, " rst PC"},         32'(PC),         32'h0000);
    check_output({name, " rst MemAddr"},    32'(MemAddr),    32'h0000);
    check_output({name, " rst Instr"},      32'(Instr),      32'h0000);
    check_output({name, " rst Halted"},     32'(Halted),     32'd0);
    tick();
    tick();
    Reset = 1'b0;
    tick();
    check_output({name, " fetch MemRdEn"},  32'(MemRdEn),    32'd1);
    check_output({name, " fetch MemAddr"},  32'(MemAddr),    32'h0000);
    check_output({name, " fetch valid"},    32'(InstrValid), 32'd0);
    tick();
    check_output({name, " wait MemRdEn"},   32'(MemRdEn),    32'd0);
    check_output({name, " wait valid"},     32'(InstrValid), 32'd0);
    tick();
    check_output({name, " hold valid"},     32'(InstrValid), 32'd1);
    check_output({name, " hold Instr"},     32'(Instr),      32'h1234);
    check_output({name, " hold PC"},        32'(PC),         32'h0000);
    model_pc = 16'h0000;
  endtask

  // Accepts the word in HOLD and follows the refetch; optionally pulses PCEn during FETCH/WAIT.
  task automatic apply_stimulus(input logic br, input logic [15:0] tgt, input logic [15:0] exp_pc,
                                input logic [15:0] exp_instr, input bit pulse, input bit exp_halt,
                                input string name);
    PCEn        = 1'b1;
    BranchTaken = br;
    TargetAddr  = tgt;
    tick();
    if (pulse) begin
      PCEn        = 1'b1;
      BranchTaken = 1'b1;
      TargetAddr  = ~exp_pc;
    end else begin
      PCEn        = 1'b0;
      BranchTaken = 1'b0;
    end
    check_output({name, " fetch MemRdEn"}, 32'(MemRdEn),    32'd1);
    check_output({name, " fetch MemAddr"}, 32'(MemAddr),    32'(exp_pc));
    check_output({name, " fetch PC"},      32'(PC),         32'(exp_pc));
    check_output({name, " fetch valid"},   32'(InstrValid), 32'd0);
    tick();
    check_output({name, " wait MemRdEn"},  32'(MemRdEn),    32'd0);
    check_output({name, " wait valid"},    32'(InstrValid), 32'd0);
    check_output({name, " wait PC"},       32'(PC),         32'(exp_pc));
    tick();
    PCEn        = 1'b0;
    BranchTaken = 1'b0;
    if (exp_halt) begin
      check_output({name, " halt Halted"},  32'(Halted),     32'd1);
      check_output({name, " halt valid"},   32'(InstrValid), 32'd0);
      check_output({name, " halt MemRdEn"}, 32'(MemRdEn),    32'd0);
      check_output({name, " halt PC"},      32'(PC),         32'(exp_pc));
    end else begin
      check_output({name, " hold valid"},   32'(InstrValid), 32'd1);
      check_output({name, " hold Instr"},   32'(Instr),      32'(exp_instr));
      check_output({name, " hold PC"},      32'(PC),         32'(exp_pc));
      check_output({name, " hold Halted"},  32'(Halted),     32'd0);
    end
    model_pc = exp_pc;
  endtask

  initial begin
    logic        br;
    logic [15:0] tgt;
    logic [15:0] nxt;
    logic [15:0] held_instr;

    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom) & 16'h7FFF;
    mem[16'h0000] = 16'h1234;
    mem[16'h0001] = 16'hB001;
    mem[16'h0002] = 16'h2002;
    mem[16'h0040] = 16'hA040;
    mem[16'h0041] = 16'hA041;
    mem[16'hFFFF] = 16'hBFFF;

    vecs[0] = '{1'b0, 16'h0000, 16'h0001, 16'hB001};
    vecs[1] = '{1'b1, 16'hFFFF, 16'hFFFF, 16'hBFFF};
    vecs[2] = '{1'b0, 16'h0000, 16'h0000, 16'h1234};
    vecs[3] = '{1'b1, 16'h0040, 16'h0040, 16'hA040};
    vecs[4] = '{1'b1, 16'h0040, 16'h0040, 16'hA040};
    vecs[5] = '{1'b0, 16'h5555, 16'h0041, 16'hA041};

    Reset       = 1'b0;
    PCEn        = 1'b0;
    BranchTaken = 1'b0;
    TargetAddr  = 16'h0000;
    @(negedge Clk);
    run_reset_sequence("startup");

    // HOLD must be stable with no new reads while PCEn stays low.
    for (int i = 0; i < 10; i++) begin
      BranchTaken = 1'($urandom_range(0, 1));
      TargetAddr  = 16'($urandom);
      tick();
      check_output("idle hold valid",   32'(InstrValid), 32'd1);
      check_output("idle hold Instr",   32'(Instr),      32'h1234);
      check_output("idle hold PC",      32'(PC),         32'h0000);
      check_output("idle hold MemRdEn", 32'(MemRdEn),    32'd0);
    end
    BranchTaken = 1'b0;

    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i].branch, vecs[i].target, vecs[i].exp_pc, vecs[i].exp_instr,
                     1'b0, 1'b0, $sformatf("vec%0d", i));
    end

    apply_stimulus(1'b0, 16'h0000, 16'h0042, mem[16'h0042], 1'b1, 1'b0, "ignored pulse");

    for (int i = 0; i < 40; i++) begin
      for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
        BranchTaken = 1'($urandom_range(0, 1));
        TargetAddr  = 16'($urandom);
        tick();
        check_output("rand hold PC", 32'(PC), 32'(model_pc));
      end
      br  = 1'($urandom_range(0, 1));
      tgt = 16'($urandom);
      if (tgt == 16'h0002) tgt = 16'h0003;
      nxt = br ? tgt : model_pc + 16'h0001;
      apply_stimulus(br, tgt, nxt, mem[nxt], 1'($urandom_range(0, 1)), 1'b0, "rand");
    end

    // Reset in WAIT: the in-flight word for 0x40 must never appear on Instr.
    PCEn        = 1'b1;
    BranchTaken = 1'b1;
    TargetAddr  = 16'h0040;
    tick();
    PCEn        = 1'b0;
    BranchTaken = 1'b0;
    tick();
    check_output("pre-reset wait MemRdEn", 32'(MemRdEn), 32'd0);
    run_reset_sequence("reset in wait");

    mem[16'h0002] = 16'hFFFF;
    apply_stimulus(1'b0, 16'h0000, 16'h0001, 16'hB001, 1'b0, 1'b0, "halt accept1");
`ifdef IFU_HALT_DETECT_EN
    apply_stimulus(1'b0, 16'h0000, 16'h0002, 16'hFFFF, 1'b0, 1'b1, "halt accept2");
    for (int i = 0; i < 5; i++) begin
      PCEn        = 1'b1;
      BranchTaken = 1'($urandom_range(0, 1));
      TargetAddr  = 16'($urandom);
      tick();
      check_output("halted stays",   32'(Halted),     32'd1);
      check_output("halted no read", 32'(MemRdEn),    32'd0);
      check_output("halted invalid", 32'(InstrValid), 32'd0);
      check_output("halted PC",      32'(PC),         32'h0002);
    end
    PCEn = 1'b0;
`else
    apply_stimulus(1'b0, 16'h0000, 16'h0002, 16'hFFFF, 1'b0, 1'b0, "halt word plain");
    held_instr = Instr;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("plain halt word valid",  32'(InstrValid), 32'd1);
      check_output("plain halt word Instr",  32'(Instr),      32'hFFFF);
      check_output("plain halt word Halted", 32'(Halted),     32'd0);
    end
    check_output("plain halt word latched", 32'(held_instr), 32'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
